// File: rtl/vga_timing_gen.sv
// Raster timing generator: free-running pixel/line counters with registered syncs,
// blank and line/frame strobes, all aligned to the hcount/vcount they describe.
module vga_timing_gen #(
    parameter int   H_ACTIVE = 800,
    parameter int   H_FP     = 56,
    parameter int   H_SYNC   = 120,
    parameter int   H_BP     = 64,
    parameter int   V_ACTIVE = 600,
    parameter int   V_FP     = 37,
    parameter int   V_SYNC   = 6,
    parameter int   V_BP     = 23,
    parameter logic SYNC_POL = 1'b1
) (
    input  logic        vclk,
    input  logic        rst,
    input  logic        en,
    output logic [10:0] hcount,
    output logic [9:0]  vcount,
    output logic        hsync,
    output logic        vsync,
    output logic        blank,
    output logic        line_tick,
    output logic        frame_tick
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    // One bit wider than the counters so limits of exactly 2048/1024 still compare correctly.
    localparam logic [11:0] H_LAST = 12'(H_TOTAL - 1);
    localparam logic [11:0] H_VIS  = 12'(H_ACTIVE);
    localparam logic [11:0] HS_BEG = 12'(H_ACTIVE + H_FP);
    localparam logic [11:0] HS_END = 12'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [10:0] V_LAST = 11'(V_TOTAL - 1);
    localparam logic [10:0] V_VIS  = 11'(V_ACTIVE);
    localparam logic [10:0] VS_BEG = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0] VS_END = 11'(V_ACTIVE + V_FP + V_SYNC);

    if (H_TOTAL > 2048) begin : g_h_total_check
        $error("vga_timing_gen: H_TOTAL=%0d does not fit the 11-bit hcount", H_TOTAL);
    end
    if (V_TOTAL > 1024) begin : g_v_total_check
        $error("vga_timing_gen: V_TOTAL=%0d does not fit the 10-bit vcount", V_TOTAL);
    end

    logic        h_wrap;
    logic        v_wrap;
    logic [10:0] h_next;
    logic [9:0]  v_next;
    logic [11:0] h_ext;
    logic [10:0] v_ext;

    always_comb begin
        h_wrap = ({1'b0, hcount} == H_LAST);
        v_wrap = ({1'b0, vcount} == V_LAST);
        h_next = h_wrap ? 11'd0 : hcount + 11'd1;
        v_next = vcount;
        if (h_wrap) begin
            v_next = v_wrap ? 10'd0 : vcount + 10'd1;
        end
        h_ext = {1'b0, h_next};
        v_ext = {1'b0, v_next};
    end

    // NOTE: state is updated with non-blocking assignments only; the comb block above uses blocking.
    always_ff @(posedge vclk) begin
        if (rst) begin
            hcount     <= '0;
            vcount     <= '0;
            hsync      <= ~SYNC_POL;
            vsync      <= ~SYNC_POL;
            blank      <= 1'b0;
            line_tick  <= 1'b0;
            frame_tick <= 1'b0;
        end else if (en) begin
            hcount     <= h_next;
            vcount     <= v_next;
            hsync      <= ((h_ext >= HS_BEG) && (h_ext < HS_END)) ? SYNC_POL : ~SYNC_POL;
            vsync      <= ((v_ext >= VS_BEG) && (v_ext < VS_END)) ? SYNC_POL : ~SYNC_POL;
            blank      <= (h_ext >= H_VIS) || (v_ext >= V_VIS);
            line_tick  <= h_wrap;
            frame_tick <= h_wrap && v_wrap;
        end else begin
            // Frozen: levels hold, strobes must not repeat.
            line_tick  <= 1'b0;
            frame_tick <= 1'b0;
        end
    end
endmodule
